// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array controller and its neighbours
// (operand skew buffers, result drain logic).
//   state_e    : controller sequencing states; IDLE is encoded as 0 so that a
//                cleared debug state reads as IDLE.
//   cnt_width  : width of a phase counter able to hold
//                k_len + 2*(array_dim-1) without overflow.
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  function automatic int cnt_width(input int depth_w, input int array_dim);
    return depth_w + $clog2(2 * array_dim);
  endfunction

endpackage

// File: rtl/systolic_mac_ctrl.sv
// Sequencing controller for an ARRAY_DIM x ARRAY_DIM systolic MAC array.
// One pass per start pulse: CLEAR the PEs, RUN k_len + 2*(ARRAY_DIM-1)
// wavefronts, FLUSH the two-stage MAC pipeline, then DRAIN result rows.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start, k_len        launch a pass (sampled only in IDLE), inner dimension
//   busy, done          pass in progress; one-cycle completion pulse
//   mac_clr             synchronous clear to all PEs
//   load_en/mult_en/acc_en  shared PE operand/product/accumulator enables
//   rd_en, rd_addr      operand buffer read strobe and index
//   out_valid, out_ready, out_row  result row handshake and row select
//   dbg_state           current controller state (systolic_pkg::state_e)
//
// Handshake: a row transfers on a rising edge where out_valid && out_ready.
// out_valid stays high and out_row stays stable until that transfer; out_ready
// may be driven freely by the consumer.
//
// Every output is a flop. Next-cycle output values are decoded from the
// next-state/next-counter values so the outputs are exactly Moore outputs of
// the state they are shown in, without a combinational path to the ports.
module systolic_mac_ctrl
  import systolic_pkg::*;
#(
  parameter int ARRAY_DIM = 4,
  parameter int DEPTH_W   = 8,
  parameter int CNT_W     = cnt_width(DEPTH_W, ARRAY_DIM)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DEPTH_W-1:0]           k_len,
  output logic                         busy,
  output logic                         done,
  output logic                         mac_clr,
  output logic                         load_en,
  output logic                         mult_en,
  output logic                         acc_en,
  output logic                         rd_en,
  output logic [DEPTH_W-1:0]           rd_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(ARRAY_DIM)-1:0] out_row,
  output logic [2:0]                   dbg_state
);

  localparam int ROW_W = $clog2(ARRAY_DIM);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_DIM - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [DEPTH_W-1:0]   k_len_q, k_len_d;
  logic [CNT_W-1:0]     run_len;
  logic [CNT_W-1:0]     k_ext_d;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 mac_clr_q, mac_clr_d;
  logic                 load_en_q, load_en_d;
  logic                 mult_en_q, mult_en_d;
  logic                 acc_en_q, acc_en_d;
  logic                 rd_en_q, rd_en_d;
  logic [DEPTH_W-1:0]   rd_addr_q, rd_addr_d;
  logic                 out_valid_q, out_valid_d;
  logic [ROW_W-1:0]     out_row_q, out_row_d;

  // RUN length L = k_len + 2*(ARRAY_DIM-1): the extra 2*(ARRAY_DIM-1)
  // wavefronts let the skewed operands reach the far corner PE.
  assign run_len = {{(CNT_W-DEPTH_W){1'b0}}, k_len_q} + CNT_W'(2 * (ARRAY_DIM - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    k_len_d = k_len_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          k_len_d = k_len;
          cnt_d   = '0;
          row_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        row_d   = '0;
        // An empty inner dimension leaves the cleared accumulators as result.
        state_d = (k_len_q != '0) ? ST_RUN : ST_DRAIN;
      end
      ST_RUN: begin
        if (cnt_q == run_len - CNT_W'(1)) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        // cnt 0 = f0 (product of last operands), cnt 1 = f1 (final accumulate).
        if (cnt_q != '0) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        // out_valid is high throughout DRAIN, so out_ready alone means transfer.
        if (out_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            row_d   = '0;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    k_ext_d     = {{(CNT_W-DEPTH_W){1'b0}}, k_len_d};
    busy_d      = (state_d != ST_IDLE);
    mac_clr_d   = (state_d == ST_CLEAR);
    load_en_d   = (state_d == ST_RUN);
    mult_en_d   = ((state_d == ST_RUN) && (cnt_d >= CNT_W'(1))) ||
                  ((state_d == ST_FLUSH) && (cnt_d == '0));
    acc_en_d    = ((state_d == ST_RUN) && (cnt_d >= CNT_W'(2))) ||
                  (state_d == ST_FLUSH);
    rd_en_d     = (state_d == ST_RUN) && (cnt_d < k_ext_d);
    rd_addr_d   = rd_en_d ? cnt_d[DEPTH_W-1:0] : '0;
    out_valid_d = (state_d == ST_DRAIN);
    out_row_d   = (state_d == ST_DRAIN) ? row_d : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      k_len_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mac_clr_q   <= 1'b0;
      load_en_q   <= 1'b0;
      mult_en_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      k_len_q     <= k_len_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mac_clr_q   <= mac_clr_d;
      load_en_q   <= load_en_d;
      mult_en_q   <= mult_en_d;
      acc_en_q    <= acc_en_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mac_clr   = mac_clr_q;
  assign load_en   = load_en_q;
  assign mult_en   = mult_en_q;
  assign acc_en    = acc_en_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_systolic_mac_ctrl.sv
// Bench for systolic_mac_ctrl (ARRAY_DIM=4, DEPTH_W=8).
// Each pass is described by a per-cycle table built from the pass timing
// (CLEAR at cycle 1, RUN for L = k+6 cycles, two FLUSH cycles, four DRAIN
// rows, done one cycle later). A 4x4 PE-array model driven by the DUT enables
// produces the accumulators, which are compared against a reference product
// whenever a row is presented.
module tb_systolic_mac_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] k_len;
  logic       busy, done, mac_clr, load_en, mult_en, acc_en, rd_en;
  logic [7:0] rd_addr;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_row;
  logic [2:0] dbg_state;

  systolic_mac_ctrl #(.ARRAY_DIM(4), .DEPTH_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .mac_clr(mac_clr), .load_en(load_en),
    .mult_en(mult_en), .acc_en(acc_en), .rd_en(rd_en), .rd_addr(rd_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       busy, done, mac_clr, load_en, mult_en, acc_en, rd_en;
    logic [7:0] rd_addr;
    logic       out_valid;
    logic [1:0] out_row;
  } out_t;

  typedef struct {
    logic       start;
    logic [7:0] k_in;
    logic       out_ready;
    out_t       exp;
  } vec_t;

  vec_t tab[0:39];
  int   n_tab;
  out_t act;

  assign act = {busy, done, mac_clr, load_en, mult_en, acc_en, rd_en,
                rd_addr, out_valid, out_row};

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- PE array model ----------------
  int A[4][8];
  int B[8][4];
  int a_m[4][4], b_m[4][4], p_m[4][4], c_m[4][4];
  int mk;
  int ph;

  function automatic int a_in(input int i);
    int t;
    t = ph - i;
    return (t >= 0 && t < mk) ? A[i][t] : 0;
  endfunction

  function automatic int b_in(input int j);
    int t;
    t = ph - j;
    return (t >= 0 && t < mk) ? B[t][j] : 0;
  endfunction

  // Applies the effect of the coming rising edge using this cycle's enables.
  task automatic model_step();
    int na[4][4], nb[4][4], np[4][4], nc[4][4];
    if (mac_clr) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          a_m[i][j] = 0; b_m[i][j] = 0; p_m[i][j] = 0; c_m[i][j] = 0;
        end
      ph = 0;
    end else begin
      na = a_m; nb = b_m; np = p_m; nc = c_m;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          if (load_en) begin
            na[i][j] = (j == 0) ? a_in(i) : a_m[i][j-1];
            nb[i][j] = (i == 0) ? b_in(j) : b_m[i-1][j];
          end
          if (mult_en) np[i][j] = a_m[i][j] * b_m[i][j];
          if (acc_en)  nc[i][j] = c_m[i][j] + p_m[i][j];
        end
      if (load_en) ph++;
      a_m = na; b_m = nb; p_m = np; c_m = nc;
    end
  endtask

  task automatic check_row(input string tag, input int r);
    int e[4];
    logic bad;
    bad = 1'b0;
    for (int j = 0; j < 4; j++) begin
      e[j] = 0;
      for (int t = 0; t < mk; t++) e[j] += A[r][t] * B[t][j];
      if (c_m[r][j] != e[j]) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s row%0d got %0d %0d %0d %0d expected %0d %0d %0d %0d", tag, r,
               c_m[r][0], c_m[r][1], c_m[r][2], c_m[r][3], e[0], e[1], e[2], e[3]);
    end
  endtask

  // ---------------- table construction ----------------
  // Builds the per-cycle expectation for one pass with inner dimension k,
  // stalling out_ready low for `stall` cycles once row 2 is presented.
  task automatic fill_pass(input int k, input int stall);
    int l, d0, dn;
    l  = k + 6;
    d0 = (k == 0) ? 2 : l + 4;
    dn = d0 + 4 + stall;
    n_tab = dn + 2;
    mk = k;
    for (int c = 0; c < n_tab; c++) begin
      tab[c].start     = (c == 0);
      tab[c].k_in      = 8'(k);
      tab[c].out_ready = !(c >= d0 + 2 && c < d0 + 2 + stall);
      tab[c].exp       = '0;
      tab[c].exp.busy    = (c >= 1 && c < dn);
      tab[c].exp.done    = (c == dn);
      tab[c].exp.mac_clr = (c == 1);
      if (k > 0) begin
        tab[c].exp.load_en = (c >= 2 && c <= l + 1);
        tab[c].exp.rd_en   = (c >= 2 && c < 2 + k);
        tab[c].exp.rd_addr = tab[c].exp.rd_en ? 8'(c - 2) : 8'd0;
        tab[c].exp.mult_en = (c >= 3 && c <= l + 2);
        tab[c].exp.acc_en  = (c >= 4 && c <= l + 3);
      end
      tab[c].exp.out_valid = (c >= d0 && c < dn);
      if (c >= d0 && c < dn) begin
        if (c < d0 + 2)              tab[c].exp.out_row = 2'(c - d0);
        else if (c <= d0 + 2 + stall) tab[c].exp.out_row = 2'd2;
        else                         tab[c].exp.out_row = 2'd3;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Cycle c: compare the outputs shown in cycle c, advance the model across
  // edge E_c, then drive the inputs that edge E_c samples.
  task automatic run_vectors(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      n_checks++;
      if (act !== tab[c].exp) begin
        n_fail++;
        $display("FAIL %s cyc%0d outputs got %h expected %h", tag, c, act, tab[c].exp);
      end
      if (out_valid) check_row(tag, int'(out_row));
      model_step();
      start     = tab[c].start;
      k_len     = tab[c].k_in;
      out_ready = tab[c].out_ready;
    end
  endtask

  task automatic set_general();
    for (int i = 0; i < 4; i++)
      for (int t = 0; t < 8; t++) begin
        A[i][t] = i + t + 1;
        B[t][i] = 2 * t + i;
      end
  endtask

  task automatic set_identity();
    for (int i = 0; i < 4; i++)
      for (int t = 0; t < 8; t++) begin
        A[i][t] = (i == t) ? 1 : 0;
        B[t][i] = (i == t) ? 1 : 0;
      end
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if (act !== '0 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL %s got outputs %h state %0d expected outputs 0 state 0",
               tag, act, dbg_state);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc;
    logic seen;
    reset = 1'b1; start = 1'b0; k_len = '0; out_ready = 1'b0;
    mk = 0; ph = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_m[i][j] = 0; b_m[i][j] = 0; p_m[i][j] = 0; c_m[i][j] = 0;
      end
    repeat (2) @(negedge clk);
    check_idle("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    // Basic pass, k_len=3 (L=9)
    set_general();
    fill_pass(3, 0);
    run_vectors("k3", n_tab);

    // Identity matrices, k_len=4
    set_identity();
    fill_pass(4, 0);
    run_vectors("ident", n_tab);

    // Empty inner dimension: rows must read all zero
    set_general();
    fill_pass(0, 0);
    run_vectors("k0", n_tab);

    // Consumer stalls 5 cycles on row 2
    fill_pass(3, 5);
    run_vectors("stall", n_tab);

    // start during RUN is ignored; start on the done cycle launches a k=0 pass
    fill_pass(3, 0);
    tab[5].start  = 1'b1;
    tab[5].k_in   = 8'd7;
    tab[17].start = 1'b1;
    tab[17].k_in  = 8'd0;
    tab[18].exp         = '0;
    tab[18].exp.busy    = 1'b1;
    tab[18].exp.mac_clr = 1'b1;
    n_tab = 19;
    run_vectors("b2b", n_tab);
    mk = 0;
    out_ready = 1'b1;
    cyc  = 18;
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      cyc++;
      if (out_valid) check_row("b2b_k0", int'(out_row));
      model_step();
      if (done) seen = 1'b1;
    end
    n_checks++;
    if (!seen || cyc != 23) begin
      n_fail++;
      $display("FAIL b2b_done got cycle %0d (seen=%0d) expected cycle 23", cyc, seen);
    end

    // Reset in the middle of RUN (cycle 6 is RUN c=4)
    set_general();
    fill_pass(3, 0);
    run_vectors("rst_pre", 7);
    #1 reset = 1'b1;
    #1 check_idle("rst_async");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("rst_idle");
    end

    // Recovery pass with the shortest non-empty inner dimension
    fill_pass(1, 0);
    run_vectors("k1", n_tab);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_mac_ctrl.md
# systolic_mac_ctrl

Sequencing controller for an ARRAY_DIM x ARRAY_DIM systolic array of multiply-accumulate PEs. Each PE registers its operands on load_en, its product on mult_en and its accumulator on acc_en, all shared array-wide. The controller runs one matrix-multiply pass per start pulse: clear the PEs, stream k_len operand wavefronts through, flush the MAC pipeline, then hand out the result rows over a valid/ready port. It sits between the host command interface and the operand skew buffers / PE array.

## Interface
- ARRAY_DIM, 4: PEs per row and per column.
- DEPTH_W, 8: width of k_len and rd_addr.
- CNT_W, DEPTH_W + $clog2(2*ARRAY_DIM): width of the internal phase counter.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs to 0.
- start  in  1  begin a pass; sampled only in IDLE.
- k_len  in  DEPTH_W  inner dimension (operand vectors per row/column); latched on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the pass completes.
- mac_clr  out  1  synchronous clear to all PEs (drives PE reset).
- load_en, mult_en, acc_en  out  1 each  shared PE enables.
- rd_en  out  1  operand buffer read strobe.
- rd_addr  out  DEPTH_W  operand buffer read index.
- out_valid  out  1  result row available.
- out_ready  in  1  consumer accepts the row.
- out_row  out  $clog2(ARRAY_DIM)  result row select.

## Operation
- States: IDLE, CLEAR, RUN, FLUSH, DRAIN. All outputs registered (Moore). Reset value of every output is 0.
- IDLE: start=1 latches k_len and goes to CLEAR. start outside IDLE is ignored.
- CLEAR: one cycle with mac_clr=1. Goes to RUN when k_len>0, else straight to DRAIN (result is all-zero).
- RUN: phase counter c runs 0..L-1, with L = k_len + 2*(ARRAY_DIM-1), computed at CNT_W width without overflow.
  - load_en=1 throughout.
  - mult_en=(c>=1); acc_en=(c>=2).
  - rd_en=(c<k_len); rd_addr=c while rd_en, else 0.
  - Row/column skew and zero padding belong to the external skew buffers.
- FLUSH: two cycles.
  - f0: load_en=0, mult_en=1, acc_en=1.
  - f1: mult_en=0, acc_en=1.
  - Then DRAIN with out_row=0.
- DRAIN: all PE enables 0, so accumulators hold. out_valid=1, out_row=r.
  - out_valid&&out_ready: r increments.
  - Acceptance at r=ARRAY_DIM-1: state returns to IDLE with done=1 for that one cycle.
  - out_row holds while out_ready=0.
- Reset asserted in any state: immediate IDLE, counters cleared, partial pass discarded.

## Timing
- Edge E0 samples start in IDLE. Cycle after E0: CLEAR (busy=1, mac_clr=1).
- RUN occupies the next L cycles, then FLUSH 2 cycles.
- First out_valid appears CLEAR+L+2 cycles after E0.
- Minimum pass length with out_ready tied high: 1 + L + 2 + ARRAY_DIM cycles; done is in the following cycle.
- Back-to-back passes: start may be asserted in the same cycle done is high, because the state is IDLE then. Next CLEAR follows one cycle later.
- The last operand pair reaches PE(ARRAY_DIM-1, ARRAY_DIM-1) at RUN c=L-1. Its product is registered at f0 and accumulated at f1.

## Structure
- Shared package systolic_pkg: state enumeration and the CNT_W / L-width derivation helper, both reused by the skew buffer and the result drain logic.
- Single module. No sub-module is natural; the phase counter and row counter are inline registers.

## Test plan
- ARRAY_DIM=4, k_len=3, start at E0, out_ready=1:
  - mac_clr cycle 1; load_en cycles 2-10 (L=9).
  - rd_en cycles 2-4 with rd_addr 0,1,2.
  - mult_en cycles 3-11; acc_en cycles 4-12.
  - out_row 0..3 cycles 13-16; done cycle 17.
- Same run against a 4x4 PE-array model, A=B=identity padded from k_len=4: drained rows equal identity.
- k_len=0: CLEAR then DRAIN directly. load_en/mult_en/acc_en never high; all rows zero; done after 4 accepted rows.
- out_ready held low 5 cycles at r=2: out_row stays 2, out_valid stays 1, accumulator values unchanged, done delayed 5 cycles.
- reset asserted mid-RUN at c=4: all outputs 0 asynchronously. After release, state is IDLE; busy=0 until the next start.
- start pulsed during RUN and again on the done cycle: the first is ignored; the second launches a new pass with CLEAR on the next cycle.
